// File: rtl/multiword_add_seq.sv
// Sequential WIDTH*WORDS-bit adder: one WIDTH-bit add-with-carry per cycle, LSW first.
// Define MULTIWORD_ADD_SEQ_OVF_EN to add the registered two's-complement overflow output ovf.
module multiword_add_seq #(
  parameter int WIDTH = 8,
  parameter int WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] a,
  input  logic [WIDTH*WORDS-1:0] b,
  input  logic                   cin,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
  ,
  output logic                   ovf
`endif
);

  localparam int N    = WIDTH * WORDS;
  localparam int IDXW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_next;

  logic [N-1:0]    r_a;
  logic [N-1:0]    r_b;
  logic [N-1:0]    r_sum;
  logic [IDXW-1:0] r_idx;
  logic            r_carry;
  logic            r_cout;

  logic [WIDTH-1:0] w_a_word;
  logic [WIDTH-1:0] w_b_word;
  logic [WIDTH-1:0] w_s;
  logic             w_c;
  logic             w_accept;
  logic             w_last;
  logic [31:0]      w_lsb;

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign w_accept  = in_valid & in_ready;
  assign w_last    = (r_idx == LAST_IDX);
  assign sum       = r_sum;
  assign cout      = r_cout;

  // Single shared word adder; the word index selects the slice of both operands.
  assign w_lsb    = r_idx * WIDTH;
  assign w_a_word = r_a[w_lsb +: WIDTH];
  assign w_b_word = r_b[w_lsb +: WIDTH];
  assign {w_c, w_s} = {1'b0, w_a_word} + {1'b0, w_b_word} + {{WIDTH{1'b0}}, r_carry};

  // NOTE: flops use non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // NOTE: the default assignment first keeps this combinational block free of latches.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (w_accept)  w_state_next = RUN;
      RUN:     if (w_last)    w_state_next = DONE;
      DONE:    if (out_ready) w_state_next = IDLE;
      default:                w_state_next = IDLE;
    endcase
  end

  // NOTE: operands are only read after a handshake has loaded them, so they carry no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_idx   <= '0;
            r_carry <= cin;
          end
        end
        RUN: begin
          r_sum[w_lsb +: WIDTH] <= w_s;
          r_carry               <= w_c;
          if (w_last) begin
            r_cout <= w_c;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef MULTIWORD_ADD_SEQ_OVF_EN
  logic r_ovf;
  logic w_c_into_msb;

  // Carry into the top bit is recovered from the top word's MSB sum bit.
  assign w_c_into_msb = w_a_word[WIDTH-1] ^ w_b_word[WIDTH-1] ^ w_s[WIDTH-1];
  assign ovf          = r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_ovf <= w_c ^ w_c_into_msb;
    end
  end
`endif

endmodule

// File: tb/tb_multiword_add_seq.sv
// Self-checking bench for multiword_add_seq: directed cases plus random ops against an arithmetic model.
`timescale 1ns/1ps
module tb_multiword_add_seq;

  localparam int WIDTH = 8;
  localparam int WORDS = 4;
  localparam int N     = WIDTH * WORDS;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         cin;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         cout;
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
  logic         ovf;
`endif

  multiword_add_seq #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Cycle counter and handshake log, sampled mid-cycle.
  int unsigned  cyc = 0;
  int unsigned  hs_cyc[$];
  int unsigned  acc_cyc[$];
  logic [N-1:0] acc_sum[$];
  logic         acc_cout[$];

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (!rst && in_valid && in_ready) hs_cyc.push_back(cyc);
    if (!rst && out_valid && out_ready) begin
      acc_cyc.push_back(cyc);
      acc_sum.push_back(sum);
      acc_cout.push_back(cout);
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain wide arithmetic; signed overflow from the true signed sum's range.
  function automatic logic [N-1:0] m_sum(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    logic [N:0] u;
    u = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
    return u[N-1:0];
  endfunction

  function automatic logic m_cout(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    logic [N:0] u;
    u = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c};
    return u[N];
  endfunction

  function automatic logic m_ovf(input logic [N-1:0] x, input logic [N-1:0] y, input logic c);
    longint sx, sy, st, smax, smin;
    sx   = longint'(signed'(x));
    sy   = longint'(signed'(y));
    st   = sx + sy + (c ? 64'sd1 : 64'sd0);
    smax = (64'sd1 <<< (N - 1)) - 64'sd1;
    smin = -(64'sd1 <<< (N - 1));
    return (st > smax) || (st < smin);
  endfunction

  task automatic check_result(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                              input logic c);
    check({tag, "_sum"}, 64'(sum), 64'(m_sum(x, y, c)));
    check({tag, "_cout"}, 64'(cout), 64'(m_cout(x, y, c)));
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
    check({tag, "_ovf"}, 64'(ovf), 64'(m_ovf(x, y, c)));
`endif
  endtask

  // One complete op: handshake, latency, result, hold in DONE for 'hold' cycles, then accept.
  task automatic run_op(input string tag, input logic [N-1:0] x, input logic [N-1:0] y,
                        input logic c, input int hold);
    int n;
    n = 0;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_ready_wait"}, 64'(in_ready), 64'd1);
    a        = x;
    b        = y;
    cin      = c;
    in_valid = 1'b1;
    tick();
    n = 1;
    while (!out_valid && n < 50) begin
      check({tag, "_in_ready_busy"}, 64'(in_ready), 64'd0);
      in_valid = 1'($urandom_range(0, 1));
      a        = $urandom;
      b        = $urandom;
      cin      = 1'($urandom_range(0, 1));
      tick();
      n++;
    end
    check({tag, "_latency"}, 64'(n), 64'(WORDS + 1));
    check({tag, "_in_ready_done"}, 64'(in_ready), 64'd0);
    check_result(tag, x, y, c);
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      a        = $urandom;
      b        = $urandom;
      tick();
      check({tag, "_hold_valid"}, 64'(out_valid), 64'd1);
      check({tag, "_hold_ready"}, 64'(in_ready), 64'd0);
      check({tag, "_hold_sum"}, 64'(sum), 64'(m_sum(x, y, c)));
      check({tag, "_hold_cout"}, 64'(cout), 64'(m_cout(x, y, c)));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({tag, "_accept_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_accept_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_after_sum"}, 64'(sum), 64'(m_sum(x, y, c)));
  endtask

  initial begin
    int base_hs, base_acc, n;
    logic [N-1:0] x0, y0, x1, y1;
    logic c0, c1;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_sum", 64'(sum), 64'd0);
    check("reset_cout", 64'(cout), 64'd0);
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
    check("reset_ovf", 64'(ovf), 64'd0);
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Directed cases.
    run_op("basic", 32'h1234_5678, 32'h1111_1111, 1'b0, 0);
    check("basic_const", 64'(sum), 64'h2345_6789);
    run_op("ripple", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0);
    check("ripple_cout_const", 64'(cout), 64'd1);
    run_op("cin_ovf", 32'h7FFF_FFFF, 32'h0000_0000, 1'b1, 0);
    check("cin_ovf_const", 64'(sum), 64'h8000_0000);
    run_op("backpressure", 32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 10);

    // Back-to-back: in_valid held high, consumer always ready.
    x0 = $urandom; y0 = $urandom; c0 = 1'($urandom_range(0, 1));
    x1 = $urandom; y1 = $urandom; c1 = 1'($urandom_range(0, 1));
    base_hs  = hs_cyc.size();
    base_acc = acc_cyc.size();
    out_ready = 1'b1;
    a = x0; b = y0; cin = c0;
    in_valid = 1'b1;
    tick();
    a = x1; b = y1; cin = c1;
    n = 0;
    while (hs_cyc.size() < base_hs + 2 && n < 40) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    check("b2b_two_handshakes", 64'(hs_cyc.size()), 64'(base_hs + 2));
    n = 0;
    while (acc_cyc.size() < base_acc + 2 && n < 40) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    check("b2b_two_results", 64'(acc_cyc.size()), 64'(base_acc + 2));
    if (hs_cyc.size() >= base_hs + 2 && acc_cyc.size() >= base_acc + 2) begin
      check("b2b_lat0", 64'(acc_cyc[base_acc] - hs_cyc[base_hs]), 64'(WORDS + 1));
      check("b2b_spacing", 64'(hs_cyc[base_hs + 1] - hs_cyc[base_hs]), 64'(WORDS + 2));
      check("b2b_next_after_accept", 64'(hs_cyc[base_hs + 1] - acc_cyc[base_acc]), 64'd1);
      check("b2b_sum0", 64'(acc_sum[base_acc]), 64'(m_sum(x0, y0, c0)));
      check("b2b_cout0", 64'(acc_cout[base_acc]), 64'(m_cout(x0, y0, c0)));
      check("b2b_sum1", 64'(acc_sum[base_acc + 1]), 64'(m_sum(x1, y1, c1)));
      check("b2b_cout1", 64'(acc_cout[base_acc + 1]), 64'(m_cout(x1, y1, c1)));
    end
    tick();

    // Reset during the second RUN cycle.
    a = 32'h1234_5678; b = 32'h1111_1111; cin = 1'b1;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_sum", 64'(sum), 64'd0);
    check("midrst_cout", 64'(cout), 64'd0);
`ifdef MULTIWORD_ADD_SEQ_OVF_EN
    check("midrst_ovf", 64'(ovf), 64'd0);
`endif
    tick();
    tick();
    check("midrst_held_valid", 64'(out_valid), 64'd0);
    rst = 1'b0;
    tick();
    run_op("post_rst", 32'h0000_0001, 32'h0000_0001, 1'b0, 0);
    check("post_rst_const", 64'(sum), 64'h0000_0002);

    // Random ops with random backpressure, including corner operands.
    run_op("corner_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1);
    run_op("corner_neg_ovf", 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    for (int i = 0; i < 25; i++) begin
      run_op("rand", $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
